debounce4_x1: RTL and testbench

Four-channel synchronising debouncer, one stage upstream of the library's 4-input AND function. It takes four asynchronous, possibly bouncing inputs and resynchronises each one into `clk`. Each output changes only after its input has held a new level for a programmable number of cycles. It also provides the 4-input AND of the clean levels plus a one-cycle rising-edge flag, so downstream logic sees a glitch-free "all asserted" condition.

---
 rtl/debounce4_pkg.sv | 19 +
 rtl/debounce4_x1_if.sv | 32 +++
 rtl/debounce1_x1.sv | 54 +++++
 rtl/debounce4_x1.sv | 53 +++++
 tb/tb_debounce4_x1.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/debounce4_pkg.sv
// -----------------------------------------------------------------------------
// debounce4_pkg
// Shared constants and helpers for the four-channel debouncer.
//   STABLE_DEFAULT : default number of stable cycles before an output follows
//   STABLE_MIN/MAX : legal range of the STABLE parameter
//   cnt_w()        : width of the per-channel stability counter
// -----------------------------------------------------------------------------
package debounce4_pkg;

    localparam int STABLE_DEFAULT = 8;
    localparam int STABLE_MIN     = 1;
    localparam int STABLE_MAX     = 255;

    // Counter must hold 0..STABLE-1; sizing for STABLE+1 keeps STABLE=1 at one bit.
    function automatic int cnt_w(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage : debounce4_pkg

// File: rtl/debounce4_x1_if.sv
// -----------------------------------------------------------------------------
// debounce4_x1_if
// Signal bundle between the raw-input side and the debouncer.
//   i0..i3 : asynchronous raw inputs (driven by master)
//   q0..q3 : debounced levels         (driven by slave)
//   q      : AND of q0..q3            (driven by slave)
//   rise   : one-cycle rising flag of q (driven by slave)
// -----------------------------------------------------------------------------
interface debounce4_x1_if;

    logic i0;
    logic i1;
    logic i2;
    logic i3;
    logic q0;
    logic q1;
    logic q2;
    logic q3;
    logic q;
    logic rise;

    modport master (
        output i0, i1, i2, i3,
        input  q0, q1, q2, q3, q, rise
    );

    modport slave (
        input  i0, i1, i2, i3,
        output q0, q1, q2, q3, q, rise
    );

endinterface : debounce4_x1_if

// File: rtl/debounce1_x1.sv
// -----------------------------------------------------------------------------
// debounce1_x1
// One debounce channel: two-flop synchroniser, stability counter, output flop.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   din  : asynchronous raw input
//   dout : debounced level, registered
// The output follows the synchronised input only after the two have differed
// on STABLE consecutive edges; any single agreeing cycle restarts the count.
// -----------------------------------------------------------------------------
module debounce1_x1
    import debounce4_pkg::*;
#(
    parameter int STABLE = STABLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int             CW      = cnt_w(STABLE);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE - 1);

    logic          s1_r;
    logic          s2_r;
    logic [CW-1:0] cnt_r;
    logic          q_r;

    // Synchroniser, stability counter and output flop for this channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            cnt_r <= '0;
            q_r   <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            if (s2_r == q_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                // Counter is capped at CNT_MAX, so equality is the terminal test.
                q_r   <= s2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign dout = q_r;

endmodule : debounce1_x1

// File: rtl/debounce4_x1.sv
// -----------------------------------------------------------------------------
// debounce4_x1
// Four independent debounce channels plus an "all asserted" level and its
// one-cycle rising-edge flag.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of debounce4_x1_if (i0..i3 in; q0..q3, q, rise out)
// q is the AND of the channel flops; rise = q & ~q_d, where q_d is q delayed
// by one edge, so rise is high only in the first cycle q is 1.
// -----------------------------------------------------------------------------
module debounce4_x1
    import debounce4_pkg::*;
#(
    parameter int STABLE = STABLE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    debounce4_x1_if.slave      bus
);

    if (STABLE < STABLE_MIN || STABLE > STABLE_MAX) begin : g_bad_stable
        $error("debounce4_x1: STABLE=%0d outside legal range %0d..%0d",
               STABLE, STABLE_MIN, STABLE_MAX);
    end

    logic [3:0] lvl_s;
    logic       all_s;
    logic       q_d_r;

    debounce1_x1 #(.STABLE(STABLE)) u_ch0 (.clk(clk), .rst(rst), .din(bus.i0), .dout(lvl_s[0]));
    debounce1_x1 #(.STABLE(STABLE)) u_ch1 (.clk(clk), .rst(rst), .din(bus.i1), .dout(lvl_s[1]));
    debounce1_x1 #(.STABLE(STABLE)) u_ch2 (.clk(clk), .rst(rst), .din(bus.i2), .dout(lvl_s[2]));
    debounce1_x1 #(.STABLE(STABLE)) u_ch3 (.clk(clk), .rst(rst), .din(bus.i3), .dout(lvl_s[3]));

    assign all_s = &lvl_s;

    // Previous-cycle copy of the combined level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_d_r <= 1'b0;
        end else begin
            q_d_r <= all_s;
        end
    end

    assign bus.q0   = lvl_s[0];
    assign bus.q1   = lvl_s[1];
    assign bus.q2   = lvl_s[2];
    assign bus.q3   = lvl_s[3];
    assign bus.q    = all_s;
    assign bus.rise = all_s & ~q_d_r;

endmodule : debounce4_x1

// File: tb/tb_debounce4_x1.sv
// -----------------------------------------------------------------------------
// tb_debounce4_x1
// Directed scenarios with STABLE=4 (six edges from input change to output).
// Each stimulus cycle pushes its hand-computed expected outputs; a monitor
// pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_debounce4_x1;

    typedef struct packed {
        logic [3:0] q4;
        logic       q;
        logic       rise;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   step_no;
    exp_t exp_q[$];

    debounce4_x1_if bus_if ();

    debounce4_x1 #(.STABLE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, step_no, act, req);
        end
    endtask

    // One stimulus cycle per iteration: drive on negedge, queue the value
    // expected right after the following rising edge.
    task automatic run(input int n, input logic r, input logic [3:0] iv,
                       input logic [3:0] eq4, input logic er);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst       = r;
            bus_if.i0 = iv[0];
            bus_if.i1 = iv[1];
            bus_if.i2 = iv[2];
            bus_if.i3 = iv[3];
            e.q4   = eq4;
            e.q    = &eq4;
            e.rise = er;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: outputs are levels valid every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_no++;
                chk("q_levels", {4'h0, bus_if.q3, bus_if.q2, bus_if.q1, bus_if.q0}, {4'h0, e.q4});
                chk("q_and",    {7'h00, bus_if.q},    {7'h00, e.q});
                chk("rise",     {7'h00, bus_if.rise}, {7'h00, e.rise});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        checks    = 0;
        failures  = 0;
        step_no   = 0;
        rst       = 1'b1;
        bus_if.i0 = 1'b1;
        bus_if.i1 = 1'b1;
        bus_if.i2 = 1'b1;
        bus_if.i3 = 1'b1;

        // Reset with all inputs high, then full six-edge latency after release.
        run(3, 1'b1, 4'hF, 4'h0, 1'b0);
        run(5, 1'b0, 4'hF, 4'h0, 1'b0);
        run(1, 1'b0, 4'hF, 4'hF, 1'b1);
        run(2, 1'b0, 4'hF, 4'hF, 1'b0);

        // Latency: drop i2 (falls on 6th edge), then step it back high.
        run(5, 1'b0, 4'hB, 4'hF, 1'b0);
        run(1, 1'b0, 4'hB, 4'hB, 1'b0);
        run(3, 1'b0, 4'hB, 4'hB, 1'b0);
        run(5, 1'b0, 4'hF, 4'hB, 1'b0);
        run(1, 1'b0, 4'hF, 4'hF, 1'b1);
        run(1, 1'b0, 4'hF, 4'hF, 1'b0);

        // Glitch rejection on i0: bring q0 low first.
        run(5, 1'b0, 4'hE, 4'hF, 1'b0);
        run(1, 1'b0, 4'hE, 4'hE, 1'b0);
        run(2, 1'b0, 4'hE, 4'hE, 1'b0);
        run(3, 1'b0, 4'hF, 4'hE, 1'b0);   // 3-cycle pulse
        run(8, 1'b0, 4'hE, 4'hE, 1'b0);
        @(posedge clk); #2;
        chk("cnt0_cleared", {5'h00, dut.u_ch0.cnt_r}, 8'h00);
        run(4, 1'b0, 4'hF, 4'hE, 1'b0);   // 4-cycle pulse propagates
        run(1, 1'b0, 4'hE, 4'hE, 1'b0);
        run(1, 1'b0, 4'hE, 4'hF, 1'b1);
        run(3, 1'b0, 4'hE, 4'hF, 1'b0);
        run(1, 1'b0, 4'hE, 4'hE, 1'b0);
        run(2, 1'b0, 4'hE, 4'hE, 1'b0);

        // q0 rises while q1 falls on the same edge: q and rise stay 0.
        run(5, 1'b0, 4'hD, 4'hE, 1'b0);
        run(1, 1'b0, 4'hD, 4'hD, 1'b0);
        run(2, 1'b0, 4'hD, 4'hD, 1'b0);

        // Bounce on i1: 1,1,0,1,1,1,0 then 1 held.
        run(2, 1'b0, 4'hF, 4'hD, 1'b0);
        run(1, 1'b0, 4'hD, 4'hD, 1'b0);
        run(3, 1'b0, 4'hF, 4'hD, 1'b0);
        run(1, 1'b0, 4'hD, 4'hD, 1'b0);
        run(5, 1'b0, 4'hF, 4'hD, 1'b0);
        run(1, 1'b0, 4'hF, 4'hF, 1'b1);
        run(2, 1'b0, 4'hF, 4'hF, 1'b0);

        // Simultaneous: drop i3 while i0 bounces 0,1,0,1 then 1.
        run(1, 1'b0, 4'h6, 4'hF, 1'b0);
        run(1, 1'b0, 4'h7, 4'hF, 1'b0);
        run(1, 1'b0, 4'h6, 4'hF, 1'b0);
        run(2, 1'b0, 4'h7, 4'hF, 1'b0);
        run(1, 1'b0, 4'h7, 4'h7, 1'b0);
        run(3, 1'b0, 4'h7, 4'h7, 1'b0);
        run(5, 1'b0, 4'hF, 4'h7, 1'b0);
        run(1, 1'b0, 4'hF, 4'hF, 1'b1);
        run(2, 1'b0, 4'hF, 4'hF, 1'b0);

        // Reset mid-count on a rising i2.
        run(5, 1'b0, 4'hB, 4'hF, 1'b0);
        run(1, 1'b0, 4'hB, 4'hB, 1'b0);
        run(2, 1'b0, 4'hB, 4'hB, 1'b0);
        run(4, 1'b0, 4'hF, 4'hB, 1'b0);
        @(posedge clk); #2;
        chk("cnt2_midcount", {5'h00, dut.u_ch2.cnt_r}, 8'h02);
        run(1, 1'b1, 4'hF, 4'h0, 1'b0);
        run(5, 1'b0, 4'hF, 4'h0, 1'b0);
        run(1, 1'b0, 4'hF, 4'hF, 1'b1);
        run(2, 1'b0, 4'hF, 4'hF, 1'b0);

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #3;
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_debounce4_x1
